// File: rtl/prng_lfsr128_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prng_lfsr128_ctrl
//  Purpose  : Owns the 128-bit XNOR maximal-length LFSR that supplies mask
//             randomness to the masked Clyde datapath. Accepts seeds and
//             rejects the all-ones lock-up value. Runs a post-seed warm-up,
//             then serves one word per handshake to a single consumer, and
//             raises a reseed request once the output budget is spent.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    UNROLL       : LFSR stages per advance step (1..128)
//    WARMUP       : advance steps discarded after each accepted seed (0 = none)
//    RND_W        : output word width, must not exceed UNROLL
//    RESEED_AFTER : words served before a reseed is required (0 = unlimited)
//  Ports
//    clk_i          in   system clock, rising edge
//    rst_ni         in   asynchronous active-low reset
//    seed_valid_i   in   one-cycle seed strobe
//    seed_data_i    in   128-bit seed value
//    seed_err_o     out  one-cycle pulse: all-ones seed rejected
//    rnd_valid_o    out  rnd_data_o holds a fresh word
//    rnd_ready_i    in   consumer accepts the word
//    rnd_data_o     out  randomness word (low RND_W bits of the LFSR state)
//    seeded_o       out  a valid seed has been accepted since reset
//    reseed_req_o   out  output budget exhausted (level)
// ============================================================================
module prng_lfsr128_ctrl #(
    parameter int UNROLL       = 32,
    parameter int WARMUP       = 8,
    parameter int RND_W        = 32,
    parameter int RESEED_AFTER = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             seed_valid_i,
    input  logic [127:0]     seed_data_i,
    output logic             seed_err_o,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic [RND_W-1:0] rnd_data_o,
    output logic             seeded_o,
    output logic             reseed_req_o
);

    // Counter widths never drop below one bit so WARMUP=0 / RESEED_AFTER=0
    // still elaborate cleanly.
    localparam int WC_W  = (WARMUP > 0)       ? $clog2(WARMUP + 1)       : 1;
    localparam int CNT_W = (RESEED_AFTER > 0) ? $clog2(RESEED_AFTER + 1) : 1;

    localparam logic [WC_W-1:0]  WARM_INIT = WC_W'(WARMUP);
    localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(1);
    localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(RESEED_AFTER);
    localparam logic [127:0]     LOCKUP    = {128{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_EXH    = 2'd3;

    logic [127:0]     state_q,    state_d;
    logic [1:0]       fsm_q,      fsm_d;
    logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic             seed_err_q, seed_err_d;
    logic             seeded_q,   seeded_d;

    logic [127:0]     w_adv_state;
    logic [CNT_W-1:0] w_out_cnt_inc;
    logic             w_seed_ok;
    logic             w_fire;

    // UNROLL chained XNOR stages; each stage shifts left and feeds the
    // inverted parity of taps 127/125/100/98 into bit 0.
    always_comb begin
        w_adv_state = state_q;
        for (int i = 0; i < UNROLL; i++) begin
            w_adv_state = {w_adv_state[126:0],
                           ~(w_adv_state[127] ^ w_adv_state[125] ^
                             w_adv_state[100] ^ w_adv_state[98])};
        end
    end

    assign w_seed_ok     = seed_valid_i & (seed_data_i != LOCKUP);
    assign w_fire        = (fsm_q == S_RUN) & rnd_ready_i;
    assign w_out_cnt_inc = out_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        fsm_d      = fsm_q;
        warm_cnt_d = warm_cnt_q;
        out_cnt_d  = out_cnt_q;
        seed_err_d = seed_valid_i & ~w_seed_ok;
        seeded_d   = seeded_q | w_seed_ok;

        if (w_seed_ok) begin
            // A seed overrides any concurrent advance, including a fire in
            // the same cycle (that word still counts as delivered).
            state_d    = seed_data_i;
            warm_cnt_d = WARM_INIT;
            out_cnt_d  = '0;
            fsm_d      = (WARMUP == 0) ? S_RUN : S_WARMUP;
        end else begin
            case (fsm_q)
                S_WARMUP: begin
                    state_d    = w_adv_state;
                    warm_cnt_d = warm_cnt_q - WARM_LAST;
                    if (warm_cnt_q == WARM_LAST) begin
                        fsm_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fire) begin
                        state_d = w_adv_state;
                        // The counter only moves while a budget is enforced,
                        // so it can never wrap.
                        if (RESEED_AFTER != 0) begin
                            out_cnt_d = w_out_cnt_inc;
                            if (w_out_cnt_inc == BUDGET) begin
                                fsm_d = S_EXH;
                            end
                        end
                    end
                end
                S_IDLE, S_EXH: begin
                    fsm_d = fsm_q;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= '0;
            fsm_q      <= S_IDLE;
            warm_cnt_q <= '0;
            out_cnt_q  <= '0;
            seed_err_q <= 1'b0;
            seeded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fsm_q      <= fsm_d;
            warm_cnt_q <= warm_cnt_d;
            out_cnt_q  <= out_cnt_d;
            seed_err_q <= seed_err_d;
            seeded_q   <= seeded_d;
        end
    end

    // Status outputs decode the FSM register directly; no combinational path
    // from inputs.
    assign rnd_valid_o  = (fsm_q == S_RUN);
    assign reseed_req_o = (fsm_q == S_EXH);
    assign rnd_data_o   = state_q[RND_W-1:0];
    assign seed_err_o   = seed_err_q;
    assign seeded_o     = seeded_q;

endmodule
`default_nettype wire

// File: tb/tb_prng_lfsr128_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prng_lfsr128_ctrl
//  Purpose  : Self-checking bench for prng_lfsr128_ctrl. Two instances:
//             dut_a (WARMUP=0, RESEED_AFTER=3) and dut_b (WARMUP=2,
//             unlimited budget). Served words are predicted by a bit-serial
//             LFSR model, queued at fire time and compared when they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prng_lfsr128_ctrl;

    localparam logic [127:0] SEED_X = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic clk;

    logic         a_rst_n, a_seed_valid, a_rnd_ready;
    logic [127:0] a_seed_data;
    logic         a_seed_err, a_rnd_valid, a_seeded, a_reseed_req;
    logic [31:0]  a_rnd_data;

    logic         b_rst_n, b_seed_valid, b_rnd_ready;
    logic [127:0] b_seed_data;
    logic         b_seed_err, b_rnd_valid, b_seeded, b_reseed_req;
    logic [31:0]  b_rnd_data;

    logic [127:0] a_mdl, b_mdl, tmp;
    logic [31:0]  sb_q[$];
    int           n_tests, n_fail, f;

    prng_lfsr128_ctrl #(.UNROLL(32), .WARMUP(0), .RND_W(32), .RESEED_AFTER(3)) dut_a (
        .clk_i        (clk),
        .rst_ni       (a_rst_n),
        .seed_valid_i (a_seed_valid),
        .seed_data_i  (a_seed_data),
        .seed_err_o   (a_seed_err),
        .rnd_valid_o  (a_rnd_valid),
        .rnd_ready_i  (a_rnd_ready),
        .rnd_data_o   (a_rnd_data),
        .seeded_o     (a_seeded),
        .reseed_req_o (a_reseed_req)
    );

    prng_lfsr128_ctrl #(.UNROLL(32), .WARMUP(2), .RND_W(32), .RESEED_AFTER(0)) dut_b (
        .clk_i        (clk),
        .rst_ni       (b_rst_n),
        .seed_valid_i (b_seed_valid),
        .seed_data_i  (b_seed_data),
        .seed_err_o   (b_seed_err),
        .rnd_valid_o  (b_rnd_valid),
        .rnd_ready_i  (b_rnd_ready),
        .rnd_data_o   (b_rnd_data),
        .seeded_o     (b_seeded),
        .reseed_req_o (b_reseed_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference LFSR, n stages.
    function automatic logic [127:0] lfsr_adv(input logic [127:0] s, input int n);
        logic [127:0] r;
        logic         fb;
        r = s;
        for (int i = 0; i < n; i++) begin
            fb = ~(r[127] ^ r[125] ^ r[100] ^ r[98]);
            r  = {r[126:0], fb};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0h expected <scoreboard empty>", tag, got);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, {96'd0, got}, {96'd0, exp});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold ready high on dut_a for a number of cycles, predicting each word.
    task automatic a_serve(input int cycles, output int fires);
        bit fire;
        fires = 0;
        a_rnd_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            fire = a_rnd_valid && a_rnd_ready;
            if (fire) begin
                a_mdl = lfsr_adv(a_mdl, 32);
                sb_q.push_back(a_mdl[31:0]);
                fires++;
            end
            tick();
            if (fire) sb_check("a_word", a_rnd_data);
        end
        a_rnd_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        a_rst_n = 1'b0; a_seed_valid = 1'b0; a_seed_data = '0; a_rnd_ready = 1'b0;
        b_rst_n = 1'b0; b_seed_valid = 1'b0; b_seed_data = '0; b_rnd_ready = 1'b0;
        a_mdl = '0; b_mdl = '0;

        // ---------------- reset and idle ----------------
        repeat (3) tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        repeat (10) tick();
        chk("a_idle_valid",  a_rnd_valid,  0);
        chk("a_idle_seeded", a_seeded,     0);
        chk("a_idle_reseed", a_reseed_req, 0);
        chk("a_idle_data",   a_rnd_data,   0);
        chk("a_idle_err",    a_seed_err,   0);
        chk("b_idle_valid",  b_rnd_valid,  0);
        chk("b_idle_seeded", b_seeded,     0);
        chk("b_idle_data",   b_rnd_data,   0);

        // ---------------- dut_a: WARMUP=0, budget 3 ----------------
        a_seed_valid = 1'b1; a_seed_data = '0;
        tick();
        a_seed_valid = 1'b0;
        chk("a_seed0_valid",  a_rnd_valid, 1);
        chk("a_seed0_data",   a_rnd_data,  0);
        chk("a_seed0_seeded", a_seeded,    1);
        a_mdl = '0;
        a_serve(1, f);
        chk("a_fire1_word", a_rnd_data, 32'hFFFF_FFFF);
        a_serve(1, f);
        chk("a_fire2_word", a_rnd_data, 32'hFFFF_FFFF);
        a_serve(4, f);
        chk("a_fires_to_budget", f, 1);
        chk("a_exh_valid",  a_rnd_valid,  0);
        chk("a_exh_reseed", a_reseed_req, 1);

        a_seed_valid = 1'b1; a_seed_data = SEED_X;
        tick();
        a_seed_valid = 1'b0;
        chk("a_reseed_clear", a_reseed_req, 0);
        chk("a_reseed_valid", a_rnd_valid,  1);
        chk("a_reseed_data",  a_rnd_data,   32'h7654_3210);
        a_mdl = SEED_X;
        a_serve(1, f);
        // seed together with a fire: seed wins, budget restarts
        a_seed_valid = 1'b1; a_seed_data = SEED_X; a_rnd_ready = 1'b1;
        tick();
        a_seed_valid = 1'b0; a_rnd_ready = 1'b0;
        chk("a_seedfire_data",  a_rnd_data,  32'h7654_3210);
        chk("a_seedfire_valid", a_rnd_valid, 1);
        a_mdl = SEED_X;
        a_serve(6, f);
        chk("a_budget_after_reload", f, 3);
        chk("a_exh2_reseed", a_reseed_req, 1);

        // ---------------- dut_b: WARMUP=2 ----------------
        b_seed_valid = 1'b1; b_seed_data = '0;
        tick();
        b_seed_valid = 1'b0;
        chk("b_t1_valid",  b_rnd_valid, 0);
        chk("b_t1_seeded", b_seeded,    1);
        tick();
        chk("b_t2_valid", b_rnd_valid, 0);
        tick();
        chk("b_t3_valid", b_rnd_valid, 1);
        chk("b_t3_data",  b_rnd_data,  32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_hold_data",  b_rnd_data,  32'hFFFF_FFFF);
            chk("b_hold_valid", b_rnd_valid, 1);
        end

        b_seed_valid = 1'b1; b_seed_data = {128{1'b1}};
        tick();
        b_seed_valid = 1'b0;
        chk("b_lock_err",   b_seed_err,  1);
        chk("b_lock_valid", b_rnd_valid, 1);
        chk("b_lock_data",  b_rnd_data,  32'hFFFF_FFFF);
        tick();
        chk("b_lock_err_end", b_seed_err, 0);
        chk("b_lock_data2",   b_rnd_data, 32'hFFFF_FFFF);

        b_seed_valid = 1'b1; b_seed_data = '0; b_rnd_ready = 1'b1;
        tick();
        b_seed_valid = 1'b0; b_rnd_ready = 1'b0;
        chk("b_seedfire_valid", b_rnd_valid, 0);
        chk("b_seedfire_data",  b_rnd_data,  0);
        tick(); tick();
        chk("b_seedfire_run",  b_rnd_valid, 1);
        chk("b_seedfire_word", b_rnd_data,  32'hFFFF_FFFF);

        b_seed_valid = 1'b1; b_seed_data = SEED_X;
        tick();
        b_seed_valid = 1'b0;
        tick(); tick();
        tmp = lfsr_adv(SEED_X, 64);
        chk("b_warm_valid", b_rnd_valid, 1);
        chk("b_warm_data",  b_rnd_data,  {96'd0, tmp[31:0]});
        b_mdl = tmp;
        b_rnd_ready = 1'b1;
        b_mdl = lfsr_adv(b_mdl, 32);
        sb_q.push_back(b_mdl[31:0]);
        tick();
        b_rnd_ready = 1'b0;
        sb_check("b_word", b_rnd_data);

        // ---------------- async reset mid-warm-up ----------------
        b_seed_valid = 1'b1; b_seed_data = SEED_X;
        tick();
        b_seed_valid = 1'b0;
        chk("b_pre_rst_seeded", b_seeded,   1);
        chk("b_pre_rst_data",   b_rnd_data, 32'h7654_3210);
        #3;
        b_rst_n = 1'b0;
        #1;
        chk("b_arst_seeded", b_seeded,     0);
        chk("b_arst_valid",  b_rnd_valid,  0);
        chk("b_arst_data",   b_rnd_data,   0);
        chk("b_arst_reseed", b_reseed_req, 0);
        chk("b_arst_err",    b_seed_err,   0);
        tick();
        b_rst_n = 1'b1;
        tick(); tick(); tick();
        chk("b_post_rst_valid",  b_rnd_valid, 0);
        chk("b_post_rst_seeded", b_seeded,    0);
        chk("b_post_rst_data",   b_rnd_data,  0);
        b_seed_valid = 1'b1; b_seed_data = '0;
        tick();
        b_seed_valid = 1'b0;
        tick(); tick();
        chk("b_post_rst_run", b_rnd_valid, 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prng_lfsr128_ctrl.md
# prng_lfsr128_ctrl

Controller for the 128-bit XNOR maximal-length LFSR that supplies fresh mask randomness to the masked Clyde datapath. It holds the LFSR state register and accepts seeds with rejection of the lock-up value. It advances the LFSR UNROLL stages per step, enforces a post-seed warm-up, and serves randomness words to one consumer over a valid/ready handshake. It also tracks output budget and requests a reseed when the budget is exhausted.

## Interface
- UNROLL, 32: LFSR stages applied per advance step; legal range 1..128.
- WARMUP, 8: advance steps discarded after every accepted seed; 0 allowed.
- RND_W, 32: output word width; requires RND_W ≤ UNROLL.
- RESEED_AFTER, 0: words served before a reseed is required; 0 disables the limit.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_valid  in  1  one-cycle strobe; seed is always accepted unless rejected as lock-up.
- seed_data  in  128  seed value.
- seed_err  out  1  one-cycle pulse: seed was all-ones and was rejected.
- rnd_valid  out  1  rnd_data holds a fresh word.
- rnd_ready  in  1  consumer accepts the word.
- rnd_data  out  RND_W  randomness word, state[RND_W-1:0].
- seeded  out  1  at least one valid seed has been accepted since reset.
- reseed_req  out  1  output budget exhausted; level signal.

## Operation
- One LFSR stage: out = {in[126:0], ~(in[127]^in[125]^in[100]^in[98])}. An advance step applies UNROLL chained stages combinationally.
- All-ones is the XNOR lock-up state. A seed equal to 128'hFF..FF is rejected: seed_err pulses, and state, FSM and counters are unchanged.
- FSM states:
  - IDLE: after reset; no valid seed yet.
  - WARMUP: advances once per cycle while warm_cnt counts down from WARMUP.
  - RUN: serving words.
  - EXHAUSTED: budget spent.
- Transitions:
  - Accepted seed, from any state: go to WARMUP, or directly to RUN if WARMUP=0. Load state=seed_data, set warm_cnt=WARMUP and out_cnt=0.
  - WARMUP: one advance per cycle. On the cycle warm_cnt reaches 1, the advance occurs and the next state is RUN.
  - RUN: on fire (rnd_valid & rnd_ready), advance once and increment out_cnt. If RESEED_AFTER≠0 and out_cnt+1 == RESEED_AFTER, go to EXHAUSTED.
  - EXHAUSTED: hold state; wait for a seed.
- With no fire in RUN, state holds and rnd_data is stable (no spontaneous advance).
- rnd_valid = (fsm==RUN); reseed_req = (fsm==EXHAUSTED); both are registered FSM decodes.
- Seed strobe and fire in the same cycle: the fire counts as a completed transfer of the current word. The seed load then wins the state update, and out_cnt resets to 0.
- out_cnt width is clog2(RESEED_AFTER+1), minimum 1. It never wraps while the limit is enabled.

## Timing
- Reset (async assert, sync-safe deassert by system): state=0, fsm=IDLE, warm_cnt=0, out_cnt=0. Outputs: rnd_valid=0, rnd_data=0, seed_err=0, seeded=0, reseed_req=0.
- Seed accepted at cycle t:
  - State is loaded at t+1 and seeded=1 from t+1.
  - With WARMUP=0: rnd_valid=1 at t+1 and rnd_data=seed_data[RND_W-1:0].
  - With WARMUP=W>0: advances occur at edges t+2..t+W+1, and rnd_valid=1 from t+W+1 with the W-times-advanced state.
- Rejected seed at t: seed_err=1 during t+1 only.
- Fire at t: the new word is visible at t+1. Back-to-back fires are allowed: throughput is one word per cycle.
- Budget: the RESEED_AFTER-th fire at t gives rnd_valid=0 and reseed_req=1 at t+1.
- Reset asserted mid-operation forces all reset values immediately; the seed must be supplied again.

## Test plan
- Reset, then idle 10 cycles → rnd_valid=0, seeded=0, reseed_req=0, rnd_data=0.
- Defaults except WARMUP=0: seed 128'h0 at t → rnd_data=32'h00000000 valid at t+1. First fire → 32'hFFFFFFFF (state=2^32−1). Second fire → state=2^64−1, rnd_data=32'hFFFFFFFF.
- WARMUP=2, UNROLL=32: seed 0 at t → rnd_valid rises at t+3 with state=2^64−1. rnd_ready held low 5 cycles → rnd_data stable, state unchanged.
- Seed 128'hFF..FF while in RUN → seed_err pulse 1 cycle, rnd_valid stays 1, rnd_data unchanged. Seed 0 with rnd_ready=1 in the same cycle → state reloaded to 0 (warm-up path), out_cnt=0.
- RESEED_AFTER=3, WARMUP=0, rnd_ready=1 always → exactly 3 fires, then rnd_valid=0, reseed_req=1. A new seed clears reseed_req next cycle and rnd_valid returns per the WARMUP rule.
- Assert rst_n low mid-WARMUP, asynchronously between edges → all outputs go to reset values before the next clk edge. After release, fsm=IDLE.
